// File: rtl/main_mem_responder.sv
// Main-memory responder: one beat-wide read or write at a time, read data returned
// a fixed number of cycles after accept. Array contents survive reset.

module main_mem_responder_chk #(
   parameter int bw_p = 128
) (
   input logic            clk_i,
   input logic            reset_i,
   input logic            mem_valid_i,
   input logic            mem_ready_o,
   input logic [31:0]     mem_addr_i,
   input logic            mem_valid_o,
   input logic [bw_p-1:0] mem_data_o
);
   a_data_known: assert property (@(posedge clk_i) disable iff (reset_i)
      mem_valid_o |-> !$isunknown(mem_data_o));
   a_addr_known: assert property (@(posedge clk_i) disable iff (reset_i)
      (mem_valid_i && mem_ready_o) |-> !$isunknown(mem_addr_i));
endmodule

module main_mem_responder #(
   parameter int    dma_data_width_p = 4,
   parameter int    mem_words_p      = 4096,
   parameter int    latency_p        = 4,
   parameter string init_file_p      = ""
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          stall_i,
   input  logic                          mem_valid_i,
   output logic                          mem_ready_o,
   input  logic                          mem_we_i,
   input  logic [31:0]                   mem_addr_i,
   input  logic [dma_data_width_p*32-1:0] mem_wdata_i,
   output logic                          mem_valid_o,
   output logic [dma_data_width_p*32-1:0] mem_data_o
);
   localparam int aw_lp = $clog2(mem_words_p);
   localparam int cw_lp = $clog2(latency_p + 1);
   localparam int bw_lp = dma_data_width_p * 32;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

   state_e             state_q, state_d;
   logic [cw_lp-1:0]   cnt_q, cnt_d;
   logic               rd_q, rd_d;
   logic [bw_lp-1:0]   rbuf_q, rbuf_d;
   logic               valid_q, valid_d;
   logic [bw_lp-1:0]   data_q, data_d;
   logic [31:0]        mem_q [mem_words_p];
   logic [aw_lp-1:0]   base_s;
   logic [bw_lp-1:0]   beat_s;
   logic               accept_s;
   logic               unused_s;

   assign unused_s = ^{mem_addr_i[31:aw_lp+2], mem_addr_i[1:0]};

   // Beat-aligned word index and the beat currently stored there
   always_comb begin
      base_s = mem_addr_i[aw_lp+1:2] & ~aw_lp'(dma_data_width_p - 1);
      beat_s = '0;
      for (int w = 0; w < dma_data_width_p; w++) begin
         beat_s[w*32 +: 32] = mem_q[base_s + aw_lp'(w)];
      end
   end

   assign mem_ready_o = !reset_i && !stall_i && (state_q != BUSY);
   assign accept_s    = mem_valid_i && mem_ready_o;
   assign mem_valid_o = valid_q;
   assign mem_data_o  = data_q;

   // Next-state logic; the output data register only changes on entry to RESP for a read
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rd_d    = rd_q;
      rbuf_d  = rbuf_q;
      valid_d = 1'b0;
      data_d  = data_q;
      case (state_q)
         BUSY: begin
            cnt_d = cnt_q - cw_lp'(1);
            if (cnt_q == cw_lp'(1)) begin
               state_d = RESP;
               valid_d = rd_q;
               if (rd_q) begin
                  data_d = rbuf_q;
               end else begin
                  data_d = data_q;
               end
            end else begin
               state_d = BUSY;
            end
         end
         IDLE, RESP: begin
            if (accept_s) begin
               rd_d   = !mem_we_i;
               rbuf_d = mem_we_i ? rbuf_q : beat_s;
               if (latency_p == 1) begin
                  state_d = RESP;
                  cnt_d   = '0;
                  valid_d = !mem_we_i;
                  data_d  = mem_we_i ? data_q : beat_s;
               end else begin
                  state_d = BUSY;
                  cnt_d   = cw_lp'(latency_p - 1);
               end
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and response registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rd_q    <= 1'b0;
         rbuf_q  <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rd_q    <= rd_d;
         rbuf_q  <= rbuf_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   // Write commit; accept is already masked by reset so no reset branch is needed
   always_ff @(posedge clk_i) begin
      if (accept_s && mem_we_i) begin
         for (int w = 0; w < dma_data_width_p; w++) begin
            mem_q[base_s + aw_lp'(w)] <= mem_wdata_i[w*32 +: 32];
         end
      end
   end

`ifndef DISABLE_TESTING
   main_mem_responder_chk #(.bw_p(bw_lp)) u_chk (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .mem_valid_i (mem_valid_i),
      .mem_ready_o (mem_ready_o),
      .mem_addr_i  (mem_addr_i),
      .mem_valid_o (valid_q),
      .mem_data_o  (data_q)
   );
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench: a latency-4 and a latency-1 instance checked against a
// word-array reference model with cycle expectations derived from latency_p.

module tb_main_mem_responder;
   localparam int DW = 4;
   localparam int LAT = 4;
   localparam int WORDS = 4096;
   localparam int WORDS_B = 256;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          a_stall, a_vi, a_rdy, a_we, a_valid;
   logic [31:0]   a_addr;
   logic [127:0]  a_wd, a_data;
   logic          b_stall, b_vi, b_rdy, b_we, b_valid;
   logic [31:0]   b_addr;
   logic [127:0]  b_wd, b_data;

   int checks = 0;
   int errors = 0;
   logic [31:0] mm_a [int];
   logic [31:0] mm_b [int];
   logic [31:0] written_a [$];

   main_mem_responder #(.dma_data_width_p(DW), .mem_words_p(WORDS), .latency_p(LAT)) dut_a (
      .clk_i(clk), .reset_i(rst), .stall_i(a_stall), .mem_valid_i(a_vi), .mem_ready_o(a_rdy),
      .mem_we_i(a_we), .mem_addr_i(a_addr), .mem_wdata_i(a_wd), .mem_valid_o(a_valid),
      .mem_data_o(a_data));

   main_mem_responder #(.dma_data_width_p(DW), .mem_words_p(WORDS_B), .latency_p(1)) dut_b (
      .clk_i(clk), .reset_i(rst), .stall_i(b_stall), .mem_valid_i(b_vi), .mem_ready_o(b_rdy),
      .mem_we_i(b_we), .mem_addr_i(b_addr), .mem_wdata_i(b_wd), .mem_valid_o(b_valid),
      .mem_data_o(b_data));

   function automatic int beat_base(input logic [31:0] ad, input int words);
      int idx;
      idx = int'((ad >> 2) % words);
      return idx - (idx % DW);
   endfunction

   function automatic logic [127:0] exp_a(input logic [31:0] ad);
      logic [127:0] r;
      int b;
      b = beat_base(ad, WORDS);
      for (int w = 0; w < DW; w++) r[w*32 +: 32] = mm_a.exists(b + w) ? mm_a[b + w] : 32'h0;
      return r;
   endfunction

   function automatic logic [127:0] exp_b(input logic [31:0] ad);
      logic [127:0] r;
      int b;
      b = beat_base(ad, WORDS_B);
      for (int w = 0; w < DW; w++) r[w*32 +: 32] = mm_b.exists(b + w) ? mm_b[b + w] : 32'h0;
      return r;
   endfunction

   function automatic logic [127:0] rand_beat();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic a_write(input logic [31:0] ad, input logic [127:0] d);
      int n = 0;
      int b;
      a_vi = 1'b1; a_we = 1'b1; a_addr = ad; a_wd = d;
      while (a_rdy !== 1'b1 && n < 50) begin step(); n++; end
      checks++;
      if (a_rdy !== 1'b1) begin errors++; $display("FAIL write_ready got %b want 1", a_rdy); end
      b = beat_base(ad, WORDS);
      for (int w = 0; w < DW; w++) mm_a[b + w] = d[w*32 +: 32];
      written_a.push_back(ad);
      step();
      a_vi = 1'b0; a_we = 1'b0;
   endtask

   task automatic a_read(input logic [31:0] ad);
      int n = 0;
      logic [127:0] exp;
      a_vi = 1'b1; a_we = 1'b0; a_addr = ad;
      while (a_rdy !== 1'b1 && n < 50) begin step(); n++; end
      checks++;
      if (a_rdy !== 1'b1) begin errors++; $display("FAIL read_ready got %b want 1", a_rdy); end
      exp = exp_a(ad);
      step();
      a_vi = 1'b0;
      for (int i = 1; i < LAT; i++) begin
         checks++;
         if (a_valid !== 1'b0 || a_rdy !== 1'b0) begin
            errors++; $display("FAIL read_wait cyc %0d valid %b ready %b want 0 0", i, a_valid, a_rdy);
         end
         step();
      end
      checks++;
      if (a_valid !== 1'b1) begin errors++; $display("FAIL read_valid addr %h got %b want 1", ad, a_valid); end
      checks++;
      if (a_data !== exp) begin errors++; $display("FAIL read_data addr %h got %h want %h", ad, a_data, exp); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(); step();
      checks++;
      if (a_valid !== 1'b0 || a_data !== 128'h0 || a_rdy !== 1'b0) begin
         errors++; $display("FAIL reset_a valid %b data %h ready %b want 0 0 0", a_valid, a_data, a_rdy);
      end
      checks++;
      if (b_valid !== 1'b0 || b_data !== 128'h0 || b_rdy !== 1'b0) begin
         errors++; $display("FAIL reset_b valid %b data %h ready %b want 0 0 0", b_valid, b_data, b_rdy);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin
         errors++; $display("FAIL reset_ready a %b b %b want 1 1", a_rdy, b_rdy);
      end
   endtask

   task automatic test_write_read();
      int n = 0;
      logic [127:0] last;
      a_write(32'h40, {32'd4, 32'd3, 32'd2, 32'd1});
      while (a_rdy !== 1'b1 && n < 10) begin
         checks++;
         if (a_valid !== 1'b0) begin errors++; $display("FAIL write_no_valid got %b want 0", a_valid); end
         step(); n++;
      end
      checks++;
      if (n != LAT - 1) begin errors++; $display("FAIL write_busy_cycles got %0d want %0d", n, LAT - 1); end
      a_read(32'h40);
      checks++;
      if (a_data !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
         errors++; $display("FAIL first_read got %h want 00000004000000030000000200000001", a_data);
      end
      for (int i = 0; i < 6; i++) a_write($urandom() & 32'hFFFF_FFF0, rand_beat());
      for (int i = 0; i < 6; i++) a_read(written_a[$urandom_range(written_a.size() - 1)]);
      last = a_data;
      step();
      a_write(32'h0000_2000, rand_beat());
      for (int i = 0; i < LAT + 1; i++) step();
      checks++;
      if (a_data !== last) begin errors++; $display("FAIL data_hold got %h want %h", a_data, last); end
   endtask

   task automatic test_addr();
      a_read(32'h44);
      checks++;
      if (a_data !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
         errors++; $display("FAIL unaligned_read got %h want beat 0x40", a_data);
      end
      a_read(WORDS * 4 + 32'h40);
      checks++;
      if (a_data !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
         errors++; $display("FAIL wrap_read got %h want beat 0x40", a_data);
      end
      a_write(32'h0000_100C, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
      a_read(32'h0000_1000);
   endtask

   task automatic test_back_to_back();
      logic [127:0] q[$];
      logic [127:0] exp;
      logic prev_v = 1'b0;
      int last_acc = -1;
      int accepts = 0;
      step(); step();
      a_vi = 1'b1; a_we = 1'b0;
      a_addr = written_a[$urandom_range(written_a.size() - 1)];
      for (int cyc = 0; cyc < 40 + LAT; cyc++) begin
         if (a_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL b2b_spurious_valid cyc %0d got 1 want 0", cyc);
            end else begin
               exp = q.pop_front();
               if (a_data !== exp) begin errors++; $display("FAIL b2b_data cyc %0d got %h want %h", cyc, a_data, exp); end
            end
            checks++;
            if (prev_v) begin errors++; $display("FAIL b2b_consecutive_valid cyc %0d got 1 want 0", cyc); end
         end
         prev_v = a_valid;
         if (cyc >= 40) a_vi = 1'b0;
         if (a_vi && a_rdy) begin
            if (last_acc >= 0) begin
               checks++;
               if (cyc - last_acc != LAT) begin
                  errors++; $display("FAIL b2b_interval got %0d want %0d", cyc - last_acc, LAT);
               end
            end
            last_acc = cyc;
            accepts++;
            q.push_back(exp_a(a_addr));
            step();
            a_addr = written_a[$urandom_range(written_a.size() - 1)];
         end else begin
            step();
         end
      end
      a_vi = 1'b0;
      checks++;
      if (q.size() != 0 || accepts < 9) begin
         errors++; $display("FAIL b2b_count pending %0d accepts %0d want 0 and >=9", q.size(), accepts);
      end
   endtask

   task automatic test_latency1();
      logic [31:0] wr[$];
      logic [127:0] prev_exp;
      int b;
      b_vi = 1'b1; b_we = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b_addr = $urandom(); b_wd = rand_beat();
         checks++;
         if (b_rdy !== 1'b1 || b_valid !== 1'b0) begin
            errors++; $display("FAIL lat1_write ready %b valid %b want 1 0", b_rdy, b_valid);
         end
         b = beat_base(b_addr, WORDS_B);
         for (int w = 0; w < DW; w++) mm_b[b + w] = b_wd[w*32 +: 32];
         wr.push_back(b_addr);
         step();
      end
      b_we = 1'b0;
      prev_exp = '0;
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (b_rdy !== 1'b1) begin errors++; $display("FAIL lat1_ready cyc %0d got %b want 1", i, b_rdy); end
         if (i > 0) begin
            checks++;
            if (b_valid !== 1'b1 || b_data !== prev_exp) begin
               errors++; $display("FAIL lat1_read cyc %0d valid %b data %h want 1 %h", i, b_valid, b_data, prev_exp);
            end
         end
         b_addr = (wr[$urandom_range(wr.size() - 1)] & 32'h0000_03F0) | ($urandom() & 32'hFFFF_F00F);
         prev_exp = exp_b(b_addr);
         step();
      end
      b_vi = 1'b0;
      checks++;
      if (b_valid !== 1'b1 || b_data !== prev_exp) begin
         errors++; $display("FAIL lat1_last valid %b data %h want 1 %h", b_valid, b_data, prev_exp);
      end
      step();
      checks++;
      if (b_valid !== 1'b0) begin errors++; $display("FAIL lat1_idle valid got %b want 0", b_valid); end
   endtask

   task automatic test_stall();
      logic [127:0] exp;
      step(); step();
      a_stall = 1'b1; a_vi = 1'b1; a_we = 1'b0; a_addr = 32'h40;
      #1;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (a_rdy !== 1'b0 || a_valid !== 1'b0) begin
            errors++; $display("FAIL stall_hold cyc %0d ready %b valid %b want 0 0", i, a_rdy, a_valid);
         end
         step();
      end
      a_stall = 1'b0;
      #1;
      checks++;
      if (a_rdy !== 1'b1) begin errors++; $display("FAIL stall_release ready got %b want 1", a_rdy); end
      exp = exp_a(32'h40);
      step();
      a_vi = 1'b0; a_stall = 1'b1;
      for (int i = 1; i < LAT; i++) step();
      checks++;
      if (a_valid !== 1'b1 || a_data !== exp) begin
         errors++; $display("FAIL stall_busy_resp valid %b data %h want 1 %h", a_valid, a_data, exp);
      end
      checks++;
      if (a_rdy !== 1'b0) begin errors++; $display("FAIL stall_resp_ready got %b want 0", a_rdy); end
      a_stall = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      logic [127:0] d;
      d = rand_beat();
      a_write(32'h0000_3000, d);
      rst = 1'b1;
      step();
      rst = 1'b0;
      a_write(32'h0000_3400, rand_beat());
      for (int i = 0; i < LAT; i++) step();
      a_vi = 1'b1; a_we = 1'b0; a_addr = 32'h0000_3400;
      step();
      a_vi = 1'b0;
      step();
      rst = 1'b1;
      #1;
      checks++;
      if (a_rdy !== 1'b0) begin errors++; $display("FAIL reset_mid_ready got %b want 0", a_rdy); end
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (a_data !== 128'h0) begin errors++; $display("FAIL reset_mid_data got %h want 0", a_data); end
      for (int i = 0; i < LAT + 2; i++) begin
         checks++;
         if (a_valid !== 1'b0 || a_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_mid_idle cyc %0d valid %b ready %b want 0 1", i, a_valid, a_rdy);
         end
         step();
      end
      a_read(32'h0000_3000);
      checks++;
      if (a_data !== d) begin errors++; $display("FAIL reset_write_kept got %h want %h", a_data, d); end
      a_read(32'h0000_3400);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      a_stall = 1'b0; a_vi = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wd = '0;
      b_stall = 1'b0; b_vi = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wd = '0;
      test_reset();
      test_write_read();
      test_addr();
      test_back_to_back();
      test_latency1();
      test_stall();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
